adc_stream_framer: RTL and testbench



---
 rtl/lockin_pkg.sv | 25 ++
 rtl/adc_stream_framer_if.sv | 18 +
 rtl/adc_sample_convert.sv | 23 ++
 rtl/adc_stream_framer.sv | 187 ++++++++++++++++++
 tb/tb_adc_stream_framer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lockin_pkg.sv
// lockin_pkg
// Shared definitions for the lock-in processing chain.
//   state_t   : capture FSM states used by the ADC stream framer.
//   CNT_W     : width of sample, point and frame counters.
//   STREAM_W  : width of the sample stream between blocks.
//   sat_inc() : saturating counter increment.
package lockin_pkg;

   localparam int CNT_W    = 32;
   localparam int STREAM_W = 64;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      STREAM,
      DONE
   } state_t;

   // Counters that report totals stick at all-ones instead of wrapping
   // back to zero.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      return (&value) ? value : value + CNT_W'(1);
   endfunction

endpackage

// File: rtl/adc_stream_framer_if.sv
// adc_stream_framer_if
// Valid-only sample stream feeding the lock-in processing chain.
//   data_out       : signed sample, OUT_W bits.
//   data_out_valid : one-cycle qualifier per sample (no backpressure).
// Modports: master = stream producer, slave = stream consumer.
interface adc_stream_framer_if
   import lockin_pkg::*;
#(
   parameter int OUT_W = STREAM_W
);

   logic signed [OUT_W-1:0] data_out;
   logic                    data_out_valid;

   modport master (output data_out, output data_out_valid);
   modport slave  (input  data_out, input  data_out_valid);

endinterface

// File: rtl/adc_sample_convert.sv
// adc_sample_convert
// Combinational ADC code to signed stream sample converter.
//   adc_data : raw ADC code, ADC_W bits.
//   sample   : signed sample, sign-extended to OUT_W bits.
// With ADC_OFFSET_BIN=1 the code is offset-binary: flipping the MSB turns
// it into two's complement before sign-extension.
module adc_sample_convert #(
   parameter int ADC_W          = 14,
   parameter int OUT_W          = 64,
   parameter int ADC_OFFSET_BIN = 1
) (
   input  logic [ADC_W-1:0]        adc_data,
   output logic signed [OUT_W-1:0] sample
);

   logic [ADC_W-1:0] twos_code;

   assign twos_code = (ADC_OFFSET_BIN != 0) ?
                      {~adc_data[ADC_W-1], adc_data[ADC_W-2:0]} : adc_data;

   assign sample = OUT_W'($signed(twos_code));

endmodule

// File: rtl/adc_stream_framer.sv
// adc_stream_framer
// Producer end of the lock-in sample stream. Waits for a rising edge of
// ref_sync so the first emitted sample is point 0 of a reference cycle,
// then emits ptos_x_ciclo * frames_total converted samples and reports done.
// Ports:
//   clk, reset        : clock, synchronous active-high reset.
//   enable            : global enable; low pauses and drops incoming samples.
//   start             : one-cycle pulse arming a capture (IDLE or DONE only).
//   ptos_x_ciclo      : points per reference cycle (0 treated as 1), latched on start.
//   frames_total      : reference cycles to emit, latched on start.
//   adc_data/adc_valid: raw ADC sample and qualifier.
//   ref_sync          : reference-cycle marker level.
//   stream            : output sample stream (master modport).
//   busy, done        : capture in progress / capture finished.
//   sample_count      : samples emitted since the last start (saturating).
//   sync_error        : sticky misalignment flag.
// Optional feature: define ADC_STREAM_FRAMER_SYNC_CHECK_EN to flag sync
// edges arriving in STREAM while the point index is not 0. Without it
// sync_error is tied low.
module adc_stream_framer
   import lockin_pkg::*;
#(
   parameter int ADC_W          = 14,
   parameter int OUT_W          = STREAM_W,
   parameter int ADC_OFFSET_BIN = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               start,
   input  logic [CNT_W-1:0]   ptos_x_ciclo,
   input  logic [CNT_W-1:0]   frames_total,
   input  logic [ADC_W-1:0]   adc_data,
   input  logic               adc_valid,
   input  logic               ref_sync,
   adc_stream_framer_if.master stream,
   output logic               busy,
   output logic               done,
   output logic [CNT_W-1:0]   sample_count,
   output logic               sync_error
);

   state_t state, state_nxt;

   logic [CNT_W-1:0] ptos_q;
   logic [CNT_W-1:0] frames_q;
   logic [CNT_W-1:0] point_idx;
   logic [CNT_W-1:0] frame_idx;
   logic             ref_sync_q;
   logic             sync_pending;

   logic             sync_edge;
   logic             accept;
   logic             emit;
   logic             arm_now;
   logic             point_wrap;
   logic             last_sample;

   logic signed [OUT_W-1:0] conv_sample;

   adc_sample_convert #(
      .ADC_W          (ADC_W),
      .OUT_W          (OUT_W),
      .ADC_OFFSET_BIN (ADC_OFFSET_BIN)
   ) u_convert (
      .adc_data (adc_data),
      .sample   (conv_sample)
   );

   assign sync_edge = ref_sync & ~ref_sync_q;
   assign accept    = enable & adc_valid;

   // The total ptos*frames is never formed: the capture ends when the point
   // counter wraps on the last frame.
   assign point_wrap  = (point_idx == ptos_q - CNT_W'(1));
   assign last_sample = point_wrap && (frame_idx == frames_q - CNT_W'(1));

   assign busy = (state == ARM) || (state == STREAM);
   assign done = (state == DONE);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. In ARM a sample is taken as point 0 either when it
   // coincides with the sync edge or when an earlier edge left sync_pending
   // set. A capture of one point by one frame finishes straight from ARM.
   always_comb begin
      state_nxt = state;
      emit      = 1'b0;
      arm_now   = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start && enable) begin
               arm_now   = 1'b1;
               state_nxt = (frames_total == '0) ? DONE : ARM;
            end
         end
         ARM: begin
            if (accept && (sync_edge || sync_pending)) begin
               emit      = 1'b1;
               state_nxt = last_sample ? DONE : STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               emit = 1'b1;
               if (last_sample) begin
                  state_nxt = DONE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture parameters, counters and the registered output stage. Samples
   // taken while enable is low never reach emit, so counters simply hold.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptos_q                <= CNT_W'(1);
         frames_q              <= '0;
         point_idx             <= '0;
         frame_idx             <= '0;
         ref_sync_q            <= 1'b0;
         sync_pending          <= 1'b0;
         sample_count          <= '0;
         stream.data_out       <= '0;
         stream.data_out_valid <= 1'b0;
      end else begin
         ref_sync_q            <= ref_sync;
         stream.data_out_valid <= emit;

         if (arm_now) begin
            ptos_q       <= (ptos_x_ciclo == '0) ? CNT_W'(1) : ptos_x_ciclo;
            frames_q     <= frames_total;
            point_idx    <= '0;
            frame_idx    <= '0;
            sample_count <= '0;
            sync_pending <= 1'b0;
         end

         if ((state == ARM) && sync_edge && !accept) begin
            sync_pending <= 1'b1;
         end

         if (emit) begin
            stream.data_out <= conv_sample;
            sample_count    <= sat_inc(sample_count);
            sync_pending    <= 1'b0;
            if (point_wrap) begin
               point_idx <= '0;
               frame_idx <= frame_idx + CNT_W'(1);
            end else begin
               point_idx <= point_idx + CNT_W'(1);
            end
         end
      end
   end

`ifdef ADC_STREAM_FRAMER_SYNC_CHECK_EN
   logic sync_error_q;

   // A sync edge mid-cycle means the reference and the point counter have
   // drifted apart. Only flag it; realigning would change the sample count
   // the downstream averagers depend on.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_error_q <= 1'b0;
      end else if (arm_now) begin
         sync_error_q <= 1'b0;
      end else if ((state == STREAM) && sync_edge && (point_idx != '0)) begin
         sync_error_q <= 1'b1;
      end
   end

   assign sync_error = sync_error_q;
`else
   assign sync_error = 1'b0;
`endif

endmodule

// File: tb/tb_adc_stream_framer.sv
// tb_adc_stream_framer
// Self-checking bench for adc_stream_framer (ADC_W=14, OUT_W=64,
// offset-binary). A behavioural model tracks the capture as "samples still
// to emit" and derives the point index as emitted mod ptos; every cycle all
// outputs are compared against it. Hand sequences and a conversion table
// add fixed expected values. Honours ADC_STREAM_FRAMER_SYNC_CHECK_EN.
module tb_adc_stream_framer;
   import lockin_pkg::*;

`ifdef ADC_STREAM_FRAMER_SYNC_CHECK_EN
   localparam bit SYNC_EN = 1'b1;
`else
   localparam bit SYNC_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        enable = 1'b0;
   logic        start = 1'b0;
   logic [31:0] ptos_x_ciclo = '0;
   logic [31:0] frames_total = '0;
   logic [13:0] adc_data = '0;
   logic        adc_valid = 1'b0;
   logic        ref_sync = 1'b0;
   logic        busy;
   logic        done;
   logic [31:0] sample_count;
   logic        sync_error;

   adc_stream_framer_if #(.OUT_W(64)) stream_bus ();

   adc_stream_framer #(
      .ADC_W          (14),
      .OUT_W          (64),
      .ADC_OFFSET_BIN (1)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .start        (start),
      .ptos_x_ciclo (ptos_x_ciclo),
      .frames_total (frames_total),
      .adc_data     (adc_data),
      .adc_valid    (adc_valid),
      .ref_sync     (ref_sync),
      .stream       (stream_bus),
      .busy         (busy),
      .done         (done),
      .sample_count (sample_count),
      .sync_error   (sync_error)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: 0 idle, 1 waiting for sync, 2 streaming, 3 finished.
   int     m_phase = 0;
   bit     m_pending = 0;
   bit     m_prev_ref = 0;
   longint m_ptos = 1;
   longint m_remaining = 0;
   longint m_count = 0;
   longint m_data = 0;
   bit     m_valid = 0;
   bit     m_err = 0;

   logic [31:0] cur_ptos = '0;
   logic [31:0] cur_frames = '0;

   typedef struct {
      logic [13:0] adc;
      longint      expected;
   } conv_vec_t;

   function automatic longint convRef(input logic [13:0] code);
      return longint'(code) - 64'sd8192;
   endfunction

   task automatic check(input string name, input longint actual, input longint expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelEmit();
      m_data = convRef(adc_data);
      m_valid = 1'b1;
      m_count++;
      m_remaining--;
      m_phase = (m_remaining == 0) ? 3 : 2;
   endtask

   task automatic modelStep();
      bit edge_seen;
      bit acc;
      if (reset) begin
         m_phase = 0; m_pending = 0; m_prev_ref = 0; m_data = 0;
         m_valid = 0; m_count = 0; m_err = 0;
         return;
      end
      edge_seen = ref_sync && !m_prev_ref;
      m_prev_ref = ref_sync;
      acc = enable && adc_valid;
      m_valid = 1'b0;
      case (m_phase)
         0, 3: begin
            if (start && enable) begin
               m_ptos = (ptos_x_ciclo == 0) ? 1 : longint'(ptos_x_ciclo);
               m_remaining = m_ptos * longint'(frames_total);
               m_count = 0; m_err = 0; m_pending = 0;
               m_phase = (frames_total == 0) ? 3 : 1;
            end
         end
         1: begin
            if (edge_seen) m_pending = 1'b1;
            if (m_pending && acc) modelEmit();
         end
         default: begin
            if (SYNC_EN && edge_seen && (m_count % m_ptos) != 0) m_err = 1'b1;
            if (acc) modelEmit();
         end
      endcase
   endtask

   task automatic checkOutput();
      check("data_out_valid", longint'(stream_bus.data_out_valid), longint'(m_valid));
      check("data_out", stream_bus.data_out, m_data);
      check("sample_count", longint'(sample_count), m_count);
      check("busy", longint'(busy), longint'(m_phase == 1 || m_phase == 2));
      check("done", longint'(done), longint'(m_phase == 3));
      check("sync_error", longint'(sync_error), longint'(m_err));
   endtask

   task automatic applyStimulus(input bit rst, input bit en, input bit st,
                                input logic [13:0] d, input bit v, input bit rs);
      reset = rst; enable = en; start = st;
      ptos_x_ciclo = cur_ptos; frames_total = cur_frames;
      adc_data = d; adc_valid = v; ref_sync = rs;
      @(posedge clk);
      #1;
      modelStep();
      checkOutput();
   endtask

   task automatic doReset();
      applyStimulus(1'b1, 1'b0, 1'b0, 14'h0, 1'b0, 1'b0);
   endtask

   task automatic doStart(input logic [31:0] p, input logic [31:0] f);
      cur_ptos = p; cur_frames = f;
      applyStimulus(1'b0, 1'b1, 1'b1, 14'h0, 1'b0, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      conv_vec_t vecs[5];
      int outs;
      int first_cyc;
      bit rs;
      vecs[0] = '{14'h0000, -64'sd8192};
      vecs[1] = '{14'h3FFF,  64'sd8191};
      vecs[2] = '{14'h2001,  64'sd1};
      vecs[3] = '{14'h2000,  64'sd0};
      vecs[4] = '{14'h1FFF, -64'sd1};

      // Reset state.
      doReset();
      doReset();
      check("reset valid", longint'(stream_bus.data_out_valid), 0);
      check("reset done", longint'(done), 0);

      // ptos=4, frames=2, valid every cycle, sync edge on cycle 10.
      doStart(4, 2);
      outs = 0; first_cyc = -1;
      for (int c = 1; c <= 30; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 14'(c), 1'b1, c >= 10);
         if (stream_bus.data_out_valid) begin
            outs++;
            if (first_cyc < 0) first_cyc = c + 1;
         end
      end
      check("seq1 outputs", outs, 8);
      check("seq1 first cycle", first_cyc, 11);
      check("seq1 done", longint'(done), 1);
      check("seq1 sample_count", longint'(sample_count), 8);

      // Edge without a sample; the sample three cycles later is point 0.
      doReset();
      doStart(2, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2000, 1'b1, 1'b1);
      check("pending first valid", longint'(stream_bus.data_out_valid), 1);
      check("pending first data", stream_bus.data_out, 0);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2001, 1'b1, 1'b1);
      check("pending done after 2", longint'(done), 1);

      // Conversion table through the full datapath.
      doReset();
      doStart(1, 5);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, vecs[i].adc, 1'b1, 1'b1);
         check("conv valid", longint'(stream_bus.data_out_valid), 1);
         check("conv data", stream_bus.data_out, vecs[i].expected);
      end
      check("conv done", longint'(done), 1);

      // enable low for 5 cycles mid-frame.
      doReset();
      doStart(8, 1);
      outs = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus(1'b0, !(c >= 3 && c < 8), 1'b0, 14'(100 + c), 1'b1, 1'b1);
         if (stream_bus.data_out_valid) outs++;
      end
      check("enable gap outputs", outs, 8);
      check("enable gap count", longint'(sample_count), 8);

      // frames_total=0 goes straight to DONE; ptos=0 acts as 1.
      doReset();
      doStart(5, 0);
      check("frames0 done", longint'(done), 1);
      check("frames0 valid", longint'(stream_bus.data_out_valid), 0);
      doStart(0, 3);
      outs = 0;
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 14'(c), 1'b1, 1'b1);
         if (stream_bus.data_out_valid) outs++;
      end
      check("ptos0 outputs", outs, 3);

      // Reset mid-STREAM after 3 of 16 samples.
      doReset();
      doStart(16, 1);
      for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 1'b0, 14'h3000, 1'b1, 1'b1);
      check("midreset pre count", longint'(sample_count), 3);
      applyStimulus(1'b1, 1'b1, 1'b0, 14'h3000, 1'b1, 1'b1);
      check("midreset data", stream_bus.data_out, 0);
      check("midreset busy", longint'(busy), 0);

      // Sync edge at point 2 with ptos=4.
      doReset();
      doStart(4, 1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2100, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2101, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h0, 1'b0, 1'b1);
      check("sync error set", longint'(sync_error), longint'(SYNC_EN));
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2102, 1'b1, 1'b1);
      applyStimulus(1'b0, 1'b1, 1'b0, 14'h2103, 1'b1, 1'b1);
      check("sync error sticky", longint'(sync_error), longint'(SYNC_EN));
      doStart(4, 1);
      check("sync error cleared", longint'(sync_error), 0);

      // Randomized runs against the model.
      for (int run = 0; run < 8; run++) begin
         doReset();
         doStart($urandom_range(0, 5), $urandom_range(0, 3));
         rs = 1'b0;
         for (int c = 0; c < 90; c++) begin
            if ($urandom_range(0, 7) == 0) rs = !rs;
            if ($urandom_range(0, 30) == 0) begin
               cur_ptos = $urandom_range(0, 5);
               cur_frames = $urandom_range(0, 3);
            end
            applyStimulus(1'b0, $urandom_range(0, 99) < 85, $urandom_range(0, 39) == 0,
                          14'($urandom), $urandom_range(0, 99) < 70, rs);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
